mcu_report_sched: RTL and testbench
===================================

# mcu_report_sched

Scheduler that shares the single MCU report UART frame transmitter among up to six report sources (baud change, bad-block update, vibration data, logging write-address, on-demand write-address, init/erase done). It latches one-cycle request pulses, grants the transmitter to exactly one source at a time, waits for that source's end-of-frame level, and enforces a minimum idle gap between frames. It sits between the flash/logging control logic and the frame transmitter's per-source enable inputs.

## Interface
Parameters:
- N_REQ, 6, number of requesters; index 0 = baud change.
- URGENT0, 1, when 1 index 0 always wins over all others; when 0 it joins the round-robin.
- GAP_CYCLES, 4800, idle clk cycles forced between end of one frame and next grant (200 us at 24 MHz).
- TIMEOUT_CYCLES, 2400000, max clk cycles a grant may stay open before abort (100 ms at 24 MHz).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low (asserted when 0).
- sched_en  in  1  1 = new grants allowed; 0 = no new grant, an open grant runs to completion.
- req  in  N_REQ  one-cycle request pulses, one bit per source.
- done  in  N_REQ  end-of-frame level from transmitter, per source; held high until its enable drops.
- grant  out  N_REQ  one-hot level enable to transmitter; at most one bit high.
- ack  out  N_REQ  one-cycle pulse: frame for that source completed.
- drop  out  N_REQ  one-cycle pulse: frame for that source aborted on timeout.
- pending  out  N_REQ  latched, not-yet-granted requests.
- busy  out  1  high in GRANT_WAIT and GAP.

## Operation
- Request latch: req[k]=1 sets pending[k]; pending[k] clears on the cycle grant[k] is issued. req[k] while pending[k] already set coalesces (single frame). req[k] in the same cycle pending[k] is cleared by a grant leaves pending[k]=1 (new request, served later).
- States: IDLE, GRANT_WAIT, GAP.
- IDLE: if sched_en=1 and pending!=0, select winner, assert grant[winner], clear pending[winner], load timeout counter, go GRANT_WAIT. Otherwise stay.
- Selection: if URGENT0=1 and pending[0]=1, winner=0. Else round-robin over eligible bits starting at last_served+1, wrapping at N_REQ-1 to 0; last_served updates to winner.
- GRANT_WAIT: grant held constant. done[g]=1 for granted g -> grant all-0, ack[g] pulse, go GAP. Timeout counter reaches TIMEOUT_CYCLES-1 without done[g] -> grant all-0, drop[g] pulse, go GAP. done on non-granted bits ignored. If done and timeout coincide, done wins (ack, no drop).
- GAP: count GAP_CYCLES cycles with grant=0, then go IDLE. Requests keep latching during GAP and GRANT_WAIT.
- sched_en falling in GRANT_WAIT or GAP has no effect until return to IDLE.
- Counters sized by $clog2 of their parameter; no wrap-around possible within a state.

## Timing
- Reset (rst=0 at a clk edge): state IDLE, grant=0, ack=0, drop=0, pending=0, busy=0, last_served=N_REQ-1 (so index 1 is first round-robin candidate / index 0 first when URGENT0=0), counters 0. Reset mid-frame drops grant on the next edge; no ack/drop emitted.
- req[k] at edge t -> pending[k]=1 after t; grant[k]=1 after t+1 (if IDLE, sched_en=1, k wins); pending[k]=0 same edge.
- done[g] sampled high at edge t -> grant=0, ack[g]=1, busy=1 after t; ack low after t+1.
- GAP: first eligible new grant appears GAP_CYCLES+1 edges after the edge that dropped grant.
- Timeout: grant stays high exactly TIMEOUT_CYCLES cycles when done never arrives.
- grant never changes bit except via all-0; no back-to-back grants without GAP.

## Test plan
- Single request: req[2] pulse with N_REQ=6, GAP_CYCLES=8 -> grant=6'b000100 two edges later, done[2] after 50 cycles -> ack[2] one pulse, grant 0, next grant possible no earlier than 9 edges later.
- Round-robin: req[1],req[3],req[5] same cycle, URGENT0=1 -> grants in order 1,3,5, each separated by GAP; repeat with last_served=3 -> order 5,1,3.
- Urgent: req[0] during grant[4] -> grant[4] completes, after GAP grant[0] precedes pending[1]; URGENT0=0 -> round-robin order.
- Timeout: TIMEOUT_CYCLES=100, req[3], done held 0 -> grant[3] high exactly 100 cycles, drop[3] one pulse, ack=0; done coinciding with last cycle -> ack[3], no drop.
- Coalesce/re-request: req[2] twice while pending -> one frame; req[2] on grant edge -> second frame after GAP.
- Gating/reset: sched_en=0 with pending=6'b000110 -> no grant; raise sched_en -> grant[1]. rst=0 mid GRANT_WAIT -> all outputs 0 next edge, no ack/drop.

Source files
------------

// File: rtl/mcu_report_sched.sv
// Arbitrates the single MCU report frame transmitter among N_REQ sources:
// latches request pulses, grants one source at a time, then forces an idle gap.
module mcu_report_sched #(
  parameter int N_REQ          = 6,
  parameter bit URGENT0        = 1'b1,
  parameter int GAP_CYCLES     = 4800,
  parameter int TIMEOUT_CYCLES = 2400000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sched_en,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] ack,
  output logic [N_REQ-1:0] drop,
  output logic [N_REQ-1:0] pending,
  output logic             busy
);

  // state        | meaning
  // S_IDLE       | no frame open; grants the next winner when enabled
  // S_GRANT_WAIT | one source enabled; waiting for its done or the timeout
  // S_GAP        | enforced idle time between frames

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT_WAIT, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] drop_q, drop_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] clr;
  logic [IW-1:0]    last_q, last_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [IW-1:0]    win;
  logic [N_REQ-1:0] win_oh;
  logic             found;
  int               idx;

  // Winner: urgent index 0 first, else first pending bit after last_served.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    if (URGENT0 && pending_q[0]) begin
      found = 1'b1;
    end
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && pending_q[IW'(idx)]) begin
        win   = IW'(idx);
        found = 1'b1;
      end
    end
    win_oh = N_REQ'(1) << win;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = '0;
    drop_d  = '0;
    clr     = '0;
    last_d  = last_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (sched_en && (|pending_q)) begin
          grant_d = win_oh;
          clr     = win_oh;
          last_d  = win;
          tmo_d   = '0;
          state_d = S_GRANT_WAIT;
        end
      end
      S_GRANT_WAIT: begin
        // done has priority over a timeout expiring on the same edge
        if (|(done & grant_q)) begin
          ack_d   = grant_q;
          grant_d = '0;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          drop_d  = grant_q;
          grant_d = '0;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = S_IDLE;
        else gap_d = gap_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // a request on the grant edge survives the clear and is served later
    pending_d = (pending_q & ~clr) | req;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      ack_q     <= '0;
      drop_q    <= '0;
      pending_q <= '0;
      last_q    <= IW'(N_REQ - 1);
      tmo_q     <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      drop_q    <= drop_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
    end
  end

  assign grant   = grant_q;
  assign ack     = ack_q;
  assign drop    = drop_q;
  assign pending = pending_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_mcu_report_sched.sv
// Random-stimulus bench: two schedulers (urgent and pure round-robin) against a
// cycle-level reference model, with an emulated frame transmitter per instance.
module tb_mcu_report_sched;
  localparam int N = 6;
  localparam int G = 8;
  localparam int T = 100;
  localparam int CYCLES = 6000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, sched_en;
  logic [N-1:0] req;
  logic [N-1:0] done_u, done_r;
  logic [N-1:0] grant_u, ack_u, drop_u, pend_u;
  logic [N-1:0] grant_r, ack_r, drop_r, pend_r;
  logic         busy_u, busy_r;

  mcu_report_sched #(.N_REQ(N), .URGENT0(1'b1), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut_u (
    .clk(clk), .rst(rst), .sched_en(sched_en), .req(req), .done(done_u),
    .grant(grant_u), .ack(ack_u), .drop(drop_u), .pending(pend_u), .busy(busy_u));

  mcu_report_sched #(.N_REQ(N), .URGENT0(1'b0), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut_r (
    .clk(clk), .rst(rst), .sched_en(sched_en), .req(req), .done(done_r),
    .grant(grant_r), .ack(ack_r), .drop(drop_r), .pending(pend_r), .busy(busy_r));

  int checks = 0;
  int errors = 0;

  // reference model state, index 0 = urgent instance, 1 = round-robin instance
  int           m_gnt [2];
  int           m_age [2];
  int           m_gap [2];
  int           m_last[2];
  logic [N-1:0] m_pend[2];
  logic [N-1:0] m_ack [2];
  logic [N-1:0] m_drop[2];

  int           tx_age[2];
  int           tx_len[2];
  logic [N-1:0] prev_g[2];
  logic [N-1:0] og[2], oa[2], od[2], op[2];
  logic         ob[2];
  logic [N-1:0] d[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int u, input bit urgent);
    if (urgent && m_pend[u][0]) return 0;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last[u] + k) % N;
      if (m_pend[u][i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input int u, input bit urgent, input logic [N-1:0] dn);
    logic [N-1:0] clr;
    int w;
    clr = '0;
    if (!rst) begin
      m_gnt[u] = -1; m_age[u] = 0; m_gap[u] = 0; m_last[u] = N - 1;
      m_pend[u] = '0; m_ack[u] = '0; m_drop[u] = '0;
    end else begin
      m_ack[u] = '0;
      m_drop[u] = '0;
      if (m_gnt[u] >= 0) begin
        m_age[u]++;
        if (dn[m_gnt[u]]) begin
          m_ack[u][m_gnt[u]] = 1'b1; m_gnt[u] = -1; m_gap[u] = G;
        end else if (m_age[u] == T) begin
          m_drop[u][m_gnt[u]] = 1'b1; m_gnt[u] = -1; m_gap[u] = G;
        end
      end else if (m_gap[u] > 0) begin
        m_gap[u]--;
      end else if (sched_en && m_pend[u] != '0) begin
        w = pick(u, urgent);
        m_gnt[u] = w; m_age[u] = 0; m_last[u] = w; clr[w] = 1'b1;
      end
      m_pend[u] = (m_pend[u] & ~clr) | req;
    end
  endtask

  initial begin
    logic [N-1:0] expg;
    rst = 1'b0; sched_en = 1'b1; req = '0; done_u = '0; done_r = '0;
    for (int u = 0; u < 2; u++) begin
      tx_age[u] = 0; tx_len[u] = 0; prev_g[u] = '0; d[u] = '0;
      model_step(u, u == 0, '0);
    end
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk);
      og[0] = grant_u; oa[0] = ack_u; od[0] = drop_u; op[0] = pend_u; ob[0] = busy_u;
      og[1] = grant_r; oa[1] = ack_r; od[1] = drop_r; op[1] = pend_r; ob[1] = busy_r;
      for (int u = 0; u < 2; u++) begin
        expg = (m_gnt[u] >= 0) ? (N'(1) << m_gnt[u]) : '0;
        check($sformatf("grant%0d", u), 32'(og[u]), 32'(expg));
        check($sformatf("ack%0d", u), 32'(oa[u]), 32'(m_ack[u]));
        check($sformatf("drop%0d", u), 32'(od[u]), 32'(m_drop[u]));
        check($sformatf("pending%0d", u), 32'(op[u]), 32'(m_pend[u]));
        check($sformatf("busy%0d", u), 32'(ob[u]), 32'((m_gnt[u] >= 0) || (m_gap[u] > 0)));
      end

      rst = (cyc < 2) ? 1'b0 : ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 49) == 0) sched_en = ~sched_en;
      for (int b = 0; b < N; b++) req[b] = ($urandom_range(0, 29) == 0);

      // emulated transmitter: done rises tx_len cycles into a grant, held until grant drops
      for (int u = 0; u < 2; u++) begin
        d[u] = '0;
        if (og[u] != '0) begin
          if (og[u] != prev_g[u]) begin
            tx_age[u] = 0;
            case ($urandom_range(0, 9))
              0:       tx_len[u] = T - 1;
              1:       tx_len[u] = T;
              2:       tx_len[u] = 1000;
              default: tx_len[u] = $urandom_range(0, 15);
            endcase
          end else begin
            tx_age[u]++;
          end
          if (tx_age[u] >= tx_len[u]) d[u] = og[u];
        end
        if ($urandom_range(0, 9) == 0) d[u] = d[u] | (N'($urandom) & ~og[u]);
        prev_g[u] = og[u];
      end
      done_u = d[0];
      done_r = d[1];
      model_step(0, 1'b1, d[0]);
      model_step(1, 1'b0, d[1]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
